// File: rtl/dp_req_arbiter.sv
// dp_req_arbiter
// Round-robin arbiter and sequencer that shares one 4-bit datapath
// (enable / data_in / data_out) among NREQ=4 requesters. The winning
// requester's nibble is latched and issued with a single-cycle enable.
// The datapath result is captured LATENCY edges later and returned to
// the winner, tagged with its ID.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req         in   [3:0]  request levels, bit i = requester i
//   req_data    in   [15:0] request nibbles, requester i at [4i+3:4i]
//   gnt         out  [3:0]  one-hot single-cycle grant pulse
//   rsp_valid   out  single-cycle response strobe
//   rsp_id      out  [1:0]  owner of the response
//   rsp_data    out  [3:0]  captured datapath result (held between responses)
//   dp_enable   out  datapath enable (high in ISSUE only)
//   dp_data_in  out  [3:0]  datapath operand (held after issue)
//   dp_data_out in   [3:0]  datapath result
//   busy        out  high whenever the sequencer is not IDLE
//
// All outputs are registered: they are decoded from the next state so that
// they line up with the state they belong to.
module dp_req_arbiter #(
  parameter int LATENCY = 1,
  parameter int NREQ    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [4*NREQ-1:0]     req_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_id,
  output logic [3:0]            rsp_data,
  output logic                  dp_enable,
  output logic [3:0]            dp_data_in,
  input  logic [3:0]            dp_data_out,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t          state_q, state_d;
  logic [1:0]      last_id_q, last_id_d;
  logic [1:0]      win_id_q, win_id_d;
  logic [3:0]      win_nib_q, win_nib_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [1:0]      rsp_id_q, rsp_id_d;
  logic [3:0]      rsp_data_q, rsp_data_d;
  logic            dp_enable_q, dp_enable_d;
  logic [3:0]      dp_data_in_q, dp_data_in_d;
  logic            busy_q, busy_d;

  logic            arb_found_s;
  logic [1:0]      arb_id_s;
  logic [1:0]      arb_idx_s;

  // Round-robin search starting just after the last winner, wrapping mod 4.
  always_comb begin
    arb_found_s = 1'b0;
    arb_id_s    = 2'd0;
    arb_idx_s   = 2'd0;
    for (int i = 1; i <= NREQ; i++) begin
      arb_idx_s = last_id_q + 2'(i);
      if (!arb_found_s && req[arb_idx_s]) begin
        arb_found_s = 1'b1;
        arb_id_s    = arb_idx_s;
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  // Next-state logic and registered-output decode.
  always_comb begin
    state_d    = state_q;
    last_id_d  = last_id_q;
    win_id_d   = win_id_q;
    win_nib_d  = win_nib_q;
    cnt_d      = cnt_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        // RESP arbitrates too, so back-to-back transactions have no gap.
        if (arb_found_s) begin
          win_id_d  = arb_id_s;
          win_nib_d = req_data[{arb_id_s, 2'b00} +: 4];
          last_id_d = arb_id_s;
          state_d   = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d = dp_data_out;
          rsp_id_d   = win_id_q;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    gnt_d        = (state_d == ST_ISSUE) ? (NREQ'(1) << win_id_d) : '0;
    dp_enable_d  = (state_d == ST_ISSUE);
    // The operand is left on the bus after issue rather than cleared.
    dp_data_in_d = (state_d == ST_ISSUE) ? win_nib_d : dp_data_in_q;
    rsp_valid_d  = (state_d == ST_RESP);
    busy_d       = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_id_q    <= 2'd3;
      win_id_q     <= 2'd0;
      win_nib_q    <= 4'd0;
      cnt_q        <= 4'd0;
      gnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 2'd0;
      rsp_data_q   <= 4'd0;
      dp_enable_q  <= 1'b0;
      dp_data_in_q <= 4'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_id_q    <= last_id_d;
      win_id_q     <= win_id_d;
      win_nib_q    <= win_nib_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      dp_enable_q  <= dp_enable_d;
      dp_data_in_q <= dp_data_in_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign dp_enable  = dp_enable_q;
  assign dp_data_in = dp_data_in_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dp_req_arbiter.sv
// Directed bench for dp_req_arbiter: one LATENCY=1 instance with a
// single-register datapath and one LATENCY=4 instance with a 4-stage datapath.
module tb_dp_req_arbiter;

  logic        clk;
  logic        rst_n;

  logic [3:0]  req, gnt;
  logic [15:0] req_data;
  logic        rsp_valid, dp_enable, busy;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_data, dp_data_in, dp_data_out;

  logic [3:0]  req2, gnt2;
  logic [15:0] req_data2;
  logic        rsp_valid2, dp_enable2, busy2;
  logic [1:0]  rsp_id2;
  logic [3:0]  rsp_data2, dp_data_in2, dp_data_out2;

  logic [3:0]  dp1_q;
  logic [3:0]  s1_q, s2_q, s3_q, s4_q;

  int checks;
  int errors;

  dp_req_arbiter #(.LATENCY(1), .NREQ(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .dp_enable(dp_enable), .dp_data_in(dp_data_in), .dp_data_out(dp_data_out),
    .busy(busy)
  );

  dp_req_arbiter #(.LATENCY(4), .NREQ(4)) u_lat (
    .clk(clk), .rst_n(rst_n), .req(req2), .req_data(req_data2), .gnt(gnt2),
    .rsp_valid(rsp_valid2), .rsp_id(rsp_id2), .rsp_data(rsp_data2),
    .dp_enable(dp_enable2), .dp_data_in(dp_data_in2), .dp_data_out(dp_data_out2),
    .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model for LATENCY=1: one register enabled by dp_enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dp1_q <= 4'd0;
    else if (dp_enable) dp1_q <= dp_data_in;
  end
  assign dp_data_out = dp1_q;

  // Datapath model for LATENCY=4: four stages, first one enabled by dp_enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 4'd0; s2_q <= 4'd0; s3_q <= 4'd0; s4_q <= 4'd0;
    end else begin
      if (dp_enable2) s1_q <= dp_data_in2;
      s2_q <= s1_q;
      s3_q <= s2_q;
      s4_q <= s3_q;
    end
  end
  assign dp_data_out2 = s4_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] all_out();
    return {2'b00, gnt, rsp_valid, rsp_id, rsp_data, dp_enable, busy, 1'b0} ^
           {12'h000, dp_data_in};
  endfunction

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    req       = 4'b0000;
    req_data  = 16'h0000;
    req2      = 4'b0000;
    req_data2 = 16'h0000;

    // Reset then idle.
    repeat (3) tick();
    chk("reset_outputs", {gnt, rsp_valid, rsp_id, rsp_data, dp_enable, dp_data_in, busy}, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outputs", {gnt, rsp_valid, rsp_id, rsp_data, dp_enable, dp_data_in, busy}, 16'h0000);
    end

    // Single request from requester 0.
    req = 4'b0001; req_data = 16'h0005;
    tick();
    chk("single_gnt", {12'h000, gnt}, 16'h0001);
    chk("single_dp_en", {15'h0, dp_enable}, 16'h0001);
    chk("single_dp_in", {12'h000, dp_data_in}, 16'h0005);
    chk("single_busy", {15'h0, busy}, 16'h0001);
    req = 4'b0000;
    tick();
    chk("single_wait", {gnt, rsp_valid, dp_enable, dp_data_in}, 16'h0005 & 16'h03FF);
    tick();
    chk("single_rsp", {rsp_valid, rsp_id, rsp_data}, {9'h0, 1'b1, 2'd0, 4'h5});
    tick();
    chk("single_after", {rsp_valid, busy, rsp_data}, {10'h0, 2'b00, 4'h5});

    // Fairness skip: make requester 1 the last winner, then 3 beats 0.
    req = 4'b0010; req_data = 16'h4321;
    tick();
    chk("fair_gnt1", {12'h000, gnt}, 16'h0002);
    req = 4'b0000;
    tick(); tick();
    chk("fair_rsp1", {rsp_valid, rsp_id, rsp_data}, {9'h0, 1'b1, 2'd1, 4'h2});
    tick();
    req = 4'b1001;
    tick();
    chk("fair_gnt3", {12'h000, gnt}, 16'h0008);
    chk("fair_dp_in3", {12'h000, dp_data_in}, 16'h0004);
    tick(); tick();
    chk("fair_rsp3", {rsp_valid, rsp_id, rsp_data}, {9'h0, 1'b1, 2'd3, 4'h4});
    tick();
    chk("fair_gnt0", {12'h000, gnt}, 16'h0001);
    chk("fair_dp_in0", {12'h000, dp_data_in}, 16'h0001);
    req = 4'b0000;
    tick(); tick();
    chk("fair_rsp0", {rsp_valid, rsp_id, rsp_data}, {9'h0, 1'b1, 2'd0, 4'h1});
    tick();

    // Full contention after a fresh reset: order 0,1,2,3,0 every 3 cycles.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req = 4'b1111; req_data = 16'h4321;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] eid;
      logic [3:0] egnt;
      logic [3:0] enib;
      eid  = 2'(k % 4);
      egnt = 4'b0001 << eid;
      enib = 4'(eid) + 4'd1;
      tick();
      chk("cont_gnt", {12'h000, gnt}, {12'h000, egnt});
      chk("cont_novalid", {15'h0, rsp_valid}, 16'h0000);
      chk("cont_dp_in", {12'h000, dp_data_in}, {12'h000, enib});
      if (k == 4) req = 4'b0000;
      tick(); tick();
      chk("cont_rsp", {rsp_valid, rsp_id, rsp_data}, {9'h0, 1'b1, eid, enib});
    end
    tick();
    chk("cont_idle", {15'h0, busy}, 16'h0000);

    // Reset during WAIT drops the transaction.
    req = 4'b0010;
    tick();
    chk("mid_gnt", {12'h000, gnt}, 16'h0002);
    req = 4'b0000;
    tick();
    chk("mid_busy", {15'h0, busy}, 16'h0001);
    rst_n = 1'b0;
    #1;
    chk("mid_async", {rsp_valid, busy, gnt, dp_enable}, 16'h0000);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_rsp", {15'h0, rsp_valid}, 16'h0000);
    end
    req = 4'b0100;
    tick();
    chk("mid_gnt2", {12'h000, gnt}, 16'h0004);
    req = 4'b0000;
    tick(); tick();
    chk("mid_rsp2", {rsp_valid, rsp_id, rsp_data}, {9'h0, 1'b1, 2'd2, 4'h3});
    tick();

    // LATENCY=4 instance: response in cycle 6.
    req2 = 4'b0001; req_data2 = 16'h000A;
    tick();
    chk("lat_gnt", {12'h000, gnt2}, 16'h0001);
    chk("lat_dp_en", {15'h0, dp_enable2}, 16'h0001);
    req2 = 4'b0000;
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk("lat_early", {15'h0, rsp_valid2}, 16'h0000);
    end
    tick();
    chk("lat_rsp", {rsp_valid2, rsp_id2, rsp_data2}, {9'h0, 1'b1, 2'd0, 4'hA});
    tick();
    chk("lat_after", {rsp_valid2, busy2, rsp_data2}, {10'h0, 2'b00, 4'hA});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_req_arbiter.md
Name: dp_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the 4-bit enable/data_in/data_out datapath among four requesters.
- Latches the winning nibble and drives it into the datapath with a single-cycle enable.
- Waits a fixed pipeline latency, captures data_out, and returns it to the winner tagged with its ID.
- Sits between the requesting blocks and the datapath, in place of the free-running stimulus that currently drives it.

Parameters:
- LATENCY, 1, edges from the issue edge to the edge on which dp_data_out is sampled; legal range 1..15.
- NREQ, 4, number of requesters; fixed at 4; ID width is 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  per-requester request level; bit i belongs to requester i.
- req_data  in  16  request nibbles; requester i uses bits [4i+3:4i].
- gnt  out  4  one-hot, one-cycle grant pulse.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  2  ID of the requester that owns the response.
- rsp_data  out  4  captured datapath result.
- dp_enable  out  1  datapath enable.
- dp_data_in  out  4  datapath operand.
- dp_data_out  in  4  datapath result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - rst_n low asynchronously forces state IDLE.
  - gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, dp_enable=0, dp_data_in=0, busy=0.
  - Round-robin pointer last_id=3, so requester 0 has first priority.
  - Latency counter=0.
  - Reset mid-transaction drops the in-flight operation; no response is ever issued for it.
- States: IDLE, ISSUE, WAIT, RESP.
- Arbitration (evaluated in IDLE and in RESP):
  - Search req starting at (last_id+1) mod 4, wrapping.
  - First set bit wins: latch its ID and its req_data nibble on that edge, update last_id to the winner, go to ISSUE.
  - No req set: IDLE stays IDLE; RESP goes to IDLE.
- ISSUE (exactly 1 cycle):
  - dp_enable=1, dp_data_in=latched nibble, gnt[winner]=1.
  - Load counter with LATENCY-1; go to WAIT.
- WAIT (exactly LATENCY cycles):
  - dp_enable=0; dp_data_in holds the issued nibble and is not cleared.
  - Counter decrements each edge.
  - On the edge where counter==0: rsp_data<=dp_data_out, rsp_id<=winner, go to RESP.
  - Net effect: dp_data_out is sampled exactly LATENCY edges after the ISSUE edge.
- RESP (1 cycle):
  - rsp_valid=1.
  - Arbitration runs in this cycle, so back-to-back transactions have no IDLE gap.
  - Period per transaction is LATENCY+2 cycles.
- Timing from a request seen in cycle 0 (IDLE): gnt in cycle 1, rsp_valid in cycle 2+LATENCY.
- Between responses, rsp_data and rsp_id hold their last values.
- Requester rules:
  - Hold req and req_data until gnt is seen.
  - A req dropped before the arbitration edge is simply not considered.
  - Once the nibble is latched, a req change has no effect on the current transaction.
  - A requester wanting another transaction keeps req high through gnt; it is then re-arbitrated behind the others.
- Simultaneous requests: exactly one grant per transaction; no requester waits more than 3 other transactions.
- busy=1 in ISSUE, WAIT and RESP.

Test Plan (LATENCY=1, datapath model = one register stage enabled by dp_enable):
- Reset then idle: rst_n low 3 cycles, then high, req=0 for 10 cycles -> all outputs 0, busy=0, no gnt.
- Single request: req=4'b0001, req_data[3:0]=4'h5 -> gnt=4'b0001 in cycle 1, dp_enable=1 with dp_data_in=5 in cycle 1, rsp_valid=1 with rsp_id=0 and rsp_data=5 in cycle 3.
- Full contention: req=4'b1111 with nibbles 1,2,3,4 held high -> grant order 0,1,2,3,0 at 3-cycle spacing; rsp_data sequence 1,2,3,4,1; rsp_valid pulses 3 cycles apart.
- Fairness skip: last_id=1, req=4'b1001 -> requester 3 is granted before 0; next grant goes to 0.
- Reset mid-op: assert rst_n low during WAIT -> rsp_valid never pulses for that transaction; after release, req=4'b0100 grants 2 first.
- Latency: rebuild with LATENCY=4 and a 4-stage datapath, single request with nibble 4'hA -> rsp_valid in cycle 6 with rsp_data=A.
